// File: rtl/glb_ld_dma_addr_gen.sv
// Load-DMA address generator for one global-buffer tile: walks each valid header's
// 4-level space, issues read addresses, and pulses invalidate per completed header.
// Optional backpressure stall counter is built when GLB_LD_DMA_STALL_CNT_EN is defined.
package glb_ld_dma_pkg;
  localparam int HDR_LOOP_LEVEL = 4;
  localparam int HDR_ADDR_W     = 19;
  localparam int HDR_WORDS_W    = 16;
  localparam int HDR_STRIDE_W   = 16;

  typedef struct packed {
    logic [HDR_WORDS_W-1:0]  range;
    logic [HDR_STRIDE_W-1:0] stride;
  } dma_ld_iter_t;

  typedef struct packed {
    logic                                valid;
    logic [HDR_ADDR_W-1:0]               start_addr;
    logic [HDR_WORDS_W-1:0]              num_active_words;
    logic [HDR_WORDS_W-1:0]              num_inactive_words;
    dma_ld_iter_t [HDR_LOOP_LEVEL-1:0]   iteration;
  } dma_ld_header_t;
endpackage

module glb_ld_dma_addr_gen #(
  parameter int QUEUE_DEPTH         = 4,
  parameter int LOOP_LEVEL          = glb_ld_dma_pkg::HDR_LOOP_LEVEL,
  parameter int GLB_ADDR_WIDTH      = glb_ld_dma_pkg::HDR_ADDR_W,
  parameter int MAX_NUM_WORDS_WIDTH = glb_ld_dma_pkg::HDR_WORDS_W,
  parameter int MAX_STRIDE_WIDTH    = glb_ld_dma_pkg::HDR_STRIDE_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [1:0]                          cfg_ld_dma_mode,
  input  glb_ld_dma_pkg::dma_ld_header_t      cfg_ld_dma_header [QUEUE_DEPTH],
  input  logic                                ld_dma_start_pulse,
  output logic                                rd_req_valid,
  input  logic                                rd_req_ready,
  output logic [GLB_ADDR_WIDTH-1:0]           rd_req_addr,
  output logic [QUEUE_DEPTH-1:0]              cfg_load_dma_invalidate_pulse,
  output logic                                ld_dma_done_pulse,
  output logic                                ld_dma_busy,
  output logic [31:0]                         ld_dma_stall_cnt
);

  localparam int QP_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, ACTIVE, INACTIVE, DONE} state_t;

  state_t                                         state, state_n;
  logic [QP_W-1:0]                                q_ptr, q_ptr_n, q_ptr_inc;
  logic [LOOP_LEVEL-1:0][MAX_NUM_WORDS_WIDTH-1:0] idx, idx_n, adv_idx;
  logic [LOOP_LEVEL-1:0][GLB_ADDR_WIDTH-1:0]      cur, cur_n, adv_cur;
  logic [LOOP_LEVEL-1:0][MAX_STRIDE_WIDTH-1:0]    stride;
  logic [LOOP_LEVEL-1:0]                          lvl_last, wrapped;
  logic [MAX_NUM_WORDS_WIDTH-1:0]                 act_cnt, act_cnt_n, inact_cnt, inact_cnt_n;
  logic [QUEUE_DEPTH-1:0]                         inval, inval_n;
  logic                                           carry, hdr_last, mode_on, mode_auto, hs;
  glb_ld_dma_pkg::dma_ld_header_t                 hdr;

  assign hdr       = cfg_ld_dma_header[q_ptr];
  assign mode_on   = (cfg_ld_dma_mode == 2'd1) || (cfg_ld_dma_mode == 2'd2);
  assign mode_auto = (cfg_ld_dma_mode == 2'd2);
  assign hs        = rd_req_valid && rd_req_ready;
  assign q_ptr_inc = (q_ptr == QP_W'(QUEUE_DEPTH - 1)) ? '0 : q_ptr + QP_W'(1);

  // cur[i] holds start_addr + sum of idx[j]*stride[j] for j >= i, so cur[0] is the
  // current word address and a carry into level k reloads every lower level from cur[k].
  always_comb begin
    adv_idx  = idx;
    adv_cur  = cur;
    wrapped  = '0;
    lvl_last = '0;
    stride   = '0;
    carry    = 1'b1;
    for (int i = 0; i < LOOP_LEVEL; i++) begin
      stride[i]   = hdr.iteration[i].stride;
      lvl_last[i] = (hdr.iteration[i].range <= MAX_NUM_WORDS_WIDTH'(1)) ||
                    (idx[i] == hdr.iteration[i].range - MAX_NUM_WORDS_WIDTH'(1));
      if (carry) begin
        if (lvl_last[i]) begin
          adv_idx[i] = '0;
          wrapped[i] = 1'b1;
        end else begin
          adv_idx[i] = idx[i] + MAX_NUM_WORDS_WIDTH'(1);
          adv_cur[i] = cur[i] + GLB_ADDR_WIDTH'(stride[i]);
          carry      = 1'b0;
        end
      end
    end
    for (int i = LOOP_LEVEL - 2; i >= 0; i--) begin
      if (wrapped[i]) adv_cur[i] = adv_cur[i+1];
    end
    hdr_last = carry;
  end

  always_comb begin
    state_n     = state;
    q_ptr_n     = q_ptr;
    idx_n       = idx;
    cur_n       = cur;
    act_cnt_n   = act_cnt;
    inact_cnt_n = inact_cnt;
    inval_n     = '0;
    case (state)
      IDLE: begin
        if (ld_dma_start_pulse && mode_on) begin
          state_n = CHECK;
          q_ptr_n = '0;
        end
      end
      CHECK: begin
        // The cycle carrying the invalidate pulse is skipped: the header valid bit
        // it clears has not yet been updated by the configuration block.
        if (!mode_on) begin
          state_n = IDLE;
        end else if (inval == '0) begin
          if (hdr.valid) begin
            for (int i = 0; i < LOOP_LEVEL; i++) begin
              idx_n[i] = '0;
              cur_n[i] = hdr.start_addr;
            end
            act_cnt_n   = '0;
            inact_cnt_n = '0;
            state_n     = ACTIVE;
          end else if (!mode_auto) begin
            state_n = DONE;
          end
        end
      end
      ACTIVE: begin
        if (!mode_on) begin
          state_n = IDLE;
        end else if (hs) begin
          if (hdr_last) begin
            inval_n[q_ptr] = 1'b1;
            q_ptr_n        = q_ptr_inc;
            state_n        = (!mode_auto && q_ptr == QP_W'(QUEUE_DEPTH - 1)) ? DONE : CHECK;
          end else begin
            idx_n = adv_idx;
            cur_n = adv_cur;
            if (hdr.num_active_words != '0 &&
                act_cnt == hdr.num_active_words - MAX_NUM_WORDS_WIDTH'(1)) begin
              act_cnt_n = '0;
              if (hdr.num_inactive_words != '0) begin
                inact_cnt_n = '0;
                state_n     = INACTIVE;
              end
            end else begin
              act_cnt_n = act_cnt + MAX_NUM_WORDS_WIDTH'(1);
            end
          end
        end
      end
      INACTIVE: begin
        if (!mode_on) begin
          state_n = IDLE;
        end else if (inact_cnt == hdr.num_inactive_words - MAX_NUM_WORDS_WIDTH'(1)) begin
          inact_cnt_n = '0;
          state_n     = ACTIVE;
        end else begin
          inact_cnt_n = inact_cnt + MAX_NUM_WORDS_WIDTH'(1);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      q_ptr     <= '0;
      idx       <= '0;
      cur       <= '0;
      act_cnt   <= '0;
      inact_cnt <= '0;
      inval     <= '0;
    end else begin
      state     <= state_n;
      q_ptr     <= q_ptr_n;
      idx       <= idx_n;
      cur       <= cur_n;
      act_cnt   <= act_cnt_n;
      inact_cnt <= inact_cnt_n;
      inval     <= inval_n;
    end
  end

  assign rd_req_valid                  = (state == ACTIVE);
  assign rd_req_addr                   = cur[0];
  assign cfg_load_dma_invalidate_pulse = inval;
  assign ld_dma_done_pulse             = (state == DONE);
  assign ld_dma_busy                   = (state != IDLE);

`ifdef GLB_LD_DMA_STALL_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (state == IDLE && ld_dma_start_pulse && mode_on) begin
      stall_cnt <= '0;
    end else if (rd_req_valid && !rd_req_ready) begin
      stall_cnt <= sat_inc32(stall_cnt);
    end
  end

  assign ld_dma_stall_cnt = stall_cnt;
`else
  assign ld_dma_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_glb_ld_dma_addr_gen.sv
// Scoreboard bench for glb_ld_dma_addr_gen: expected addresses and invalidates are
// queued from a direct nested-loop model when headers are programmed.
module tb_glb_ld_dma_addr_gen;
  import glb_ld_dma_pkg::*;

  localparam int QD = 4;

  logic           clk;
  logic           reset;
  logic [1:0]     mode;
  dma_ld_header_t hdr_sw  [QD];
  dma_ld_header_t hdr_dut [QD];
  logic           start_pulse;
  logic           rd_req_valid;
  logic           rd_req_ready;
  logic [18:0]    rd_req_addr;
  logic [QD-1:0]  inval;
  logic           done;
  logic           busy;
  logic [31:0]    stall_cnt;

  glb_ld_dma_addr_gen #(.QUEUE_DEPTH(QD)) dut (
    .clk                           (clk),
    .reset                         (reset),
    .cfg_ld_dma_mode               (mode),
    .cfg_ld_dma_header             (hdr_dut),
    .ld_dma_start_pulse            (start_pulse),
    .rd_req_valid                  (rd_req_valid),
    .rd_req_ready                  (rd_req_ready),
    .rd_req_addr                   (rd_req_addr),
    .cfg_load_dma_invalidate_pulse (inval),
    .ld_dma_done_pulse             (done),
    .ld_dma_busy                   (busy),
    .ld_dma_stall_cnt              (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Header valid bits as seen by the DUT: software value masked by hardware clears.
  logic [QD-1:0] cleared;
  always_comb begin
    for (int i = 0; i < QD; i++) begin
      hdr_dut[i]       = hdr_sw[i];
      hdr_dut[i].valid = hdr_sw[i].valid & ~cleared[i];
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          hs_cnt = 0, inval_cnt = 0, done_cnt = 0;
  int          last_hs_cyc = 0, last_inval_cyc = 0, last_done_cyc = 0;
  int          rec_lo = 1 << 30;
  logic [11:0] vpat = '0;
  logic        prev_stall = 1'b0;
  logic [18:0] prev_addr = '0;
  logic [18:0] exp_addr [$];
  logic [QD-1:0] exp_inval [$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (reset) begin
      if (prev_stall && mode != 2'd0) begin
        check_val("hold_valid", rd_req_valid, 1);
        check_val("hold_addr", rd_req_addr, prev_addr);
      end
      if (rd_req_valid && rd_req_ready) begin
        if (exp_addr.size() == 0) check_val("addr_pending", exp_addr.size(), 1);
        else check_val("addr", rd_req_addr, exp_addr.pop_front());
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (inval != '0) begin
        if (exp_inval.size() == 0) check_val("inval_pending", exp_inval.size(), 1);
        else check_val("inval", inval, exp_inval.pop_front());
        cleared = cleared | inval;
        inval_cnt++;
        last_inval_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (cyc >= rec_lo && cyc < rec_lo + 12) vpat = {vpat[10:0], rd_req_valid};
      prev_stall = rd_req_valid & ~rd_req_ready;
      prev_addr  = rd_req_addr;
    end else begin
      prev_stall = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_hdrs();
    for (int i = 0; i < QD; i++) hdr_sw[i] = '0;
  endtask

  task automatic set_hdr(input int e, input logic [18:0] sa, input logic [15:0] act,
                         input logic [15:0] inact, input logic [15:0] r0, input logic [15:0] s0,
                         input logic [15:0] r1, input logic [15:0] s1);
    hdr_sw[e]                     = '0;
    hdr_sw[e].valid               = 1'b1;
    hdr_sw[e].start_addr          = sa;
    hdr_sw[e].num_active_words    = act;
    hdr_sw[e].num_inactive_words  = inact;
    hdr_sw[e].iteration[0].range  = r0;
    hdr_sw[e].iteration[0].stride = s0;
    hdr_sw[e].iteration[1].range  = r1;
    hdr_sw[e].iteration[1].stride = s1;
    hdr_sw[e].iteration[2].range  = 16'd0;
    hdr_sw[e].iteration[2].stride = 16'h0777;
    hdr_sw[e].iteration[3].range  = 16'd1;
    hdr_sw[e].iteration[3].stride = 16'h0333;
  endtask

  task automatic push_exp(input int e);
    int          r [4];
    logic [31:0] a;
    logic [QD-1:0] oh;
    for (int l = 0; l < 4; l++)
      r[l] = (hdr_sw[e].iteration[l].range == 16'd0) ? 1 : int'(hdr_sw[e].iteration[l].range);
    for (int i3 = 0; i3 < r[3]; i3++)
      for (int i2 = 0; i2 < r[2]; i2++)
        for (int i1 = 0; i1 < r[1]; i1++)
          for (int i0 = 0; i0 < r[0]; i0++) begin
            a = 32'(hdr_sw[e].start_addr)
              + 32'(i0) * 32'(hdr_sw[e].iteration[0].stride)
              + 32'(i1) * 32'(hdr_sw[e].iteration[1].stride)
              + 32'(i2) * 32'(hdr_sw[e].iteration[2].stride)
              + 32'(i3) * 32'(hdr_sw[e].iteration[3].stride);
            exp_addr.push_back(a[18:0]);
          end
    oh = QD'(1) << e;
    exp_inval.push_back(oh);
  endtask

  task automatic start_dma(input logic [1:0] m, output int t);
    mode        = m;
    start_pulse = 1'b1;
    t           = cyc;
    step();
    start_pulse = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    check_val("done_seen", done_cnt, d0 + 1);
  endtask

  task automatic end_test(input string tag);
    check_val({tag, "_addr_q_empty"}, exp_addr.size(), 0);
    check_val({tag, "_inval_q_empty"}, exp_inval.size(), 0);
    check_val({tag, "_idle"}, busy, 0);
    exp_addr.delete();
    exp_inval.delete();
    cleared = '0;
    clear_hdrs();
    step();
  endtask

  initial begin
    int t, d0, h0, i0, n;
    reset = 1'b0; mode = 2'd0; start_pulse = 1'b0; rd_req_ready = 1'b1; cleared = '0;
    clear_hdrs();
    repeat (3) step();
    check_val("rst_valid", rd_req_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_addr", rd_req_addr, 0);
    check_val("rst_inval", inval, 0);
    check_val("rst_done", done, 0);
    check_val("rst_stall", stall_cnt, 0);
    reset = 1'b1;
    step();

    // Single header, one level, NORMAL mode.
    set_hdr(0, 19'h100, 16'd0, 16'd0, 16'd4, 16'd8, 16'd1, 16'h0055);
    push_exp(0);
    d0 = done_cnt; h0 = hs_cnt;
    start_dma(2'd1, t);
    check_val("a_check_busy", busy, 1);
    check_val("a_check_valid", rd_req_valid, 0);
    step();
    check_val("a_first_valid", rd_req_valid, 1);
    check_val("a_first_addr", rd_req_addr, 19'h100);
    wait_done(40, d0);
    check_val("a_hs", hs_cnt - h0, 4);
    check_val("a_last_hs_cyc", last_hs_cyc, t + 5);
    check_val("a_inval_cyc", last_inval_cyc, t + 6);
    check_val("a_done_cyc", last_done_cyc, t + 8);
    end_test("a");

    // Two levels.
    set_hdr(0, 19'h0, 16'd0, 16'd0, 16'd2, 16'd8, 16'd3, 16'h0040);
    push_exp(0);
    d0 = done_cnt; h0 = hs_cnt;
    start_dma(2'd1, t);
    wait_done(40, d0);
    check_val("b_hs", hs_cnt - h0, 6);
    end_test("b");

    // Active/inactive gap pattern.
    set_hdr(0, 19'h400, 16'd2, 16'd3, 16'd6, 16'd4, 16'd1, 16'd0);
    push_exp(0);
    d0 = done_cnt; h0 = hs_cnt; vpat = '0;
    start_dma(2'd1, t);
    rec_lo = t + 2;
    wait_done(60, d0);
    rec_lo = 1 << 30;
    check_val("c_valid_pattern", vpat, 12'b110001100011);
    check_val("c_hs", hs_cnt - h0, 6);
    end_test("c");

    // Backpressure for 5 cycles after two words.
    set_hdr(0, 19'h2000, 16'd0, 16'd0, 16'd8, 16'h0010, 16'd1, 16'd0);
    push_exp(0);
    d0 = done_cnt; h0 = hs_cnt;
    start_dma(2'd1, t);
    repeat (3) step();
    rd_req_ready = 1'b0;
    repeat (5) step();
    rd_req_ready = 1'b1;
    wait_done(60, d0);
    check_val("d_hs", hs_cnt - h0, 8);
    check_val("d_last_hs_cyc", last_hs_cyc, t + 14);
`ifdef GLB_LD_DMA_STALL_CNT_EN
    check_val("d_stall_cnt", stall_cnt, 5);
`else
    check_val("d_stall_cnt", stall_cnt, 0);
`endif
    end_test("d");

    // AUTO mode across all entries, then poll and abort.
    for (int e = 0; e < QD; e++) begin
      set_hdr(e, 19'h1000 + 19'(e * 'h100), 16'd0, 16'd0, 16'd2, 16'd4, 16'd1, 16'd0);
      push_exp(e);
    end
    i0 = inval_cnt; d0 = done_cnt; n = 0;
    start_dma(2'd2, t);
    while (inval_cnt - i0 < 4 && n < 100) begin
      step();
      n++;
    end
    check_val("e_inval_n", inval_cnt - i0, 4);
    check_val("e_last_inval_cyc", last_inval_cyc, t + 16);
    repeat (4) step();
    check_val("e_poll_busy", busy, 1);
    check_val("e_poll_valid", rd_req_valid, 0);
    mode = 2'd0;
    step();
    check_val("e_off_busy", busy, 0);
    check_val("e_off_no_done", done_cnt, d0);
    end_test("e");

    // Reset during the third word.
    set_hdr(0, 19'h3000, 16'd0, 16'd0, 16'd8, 16'h0020, 16'd1, 16'd0);
    push_exp(0);
    start_dma(2'd1, t);
    repeat (3) step();
    check_val("f_third_valid", rd_req_valid, 1);
    check_val("f_third_addr", rd_req_addr, 19'h3040);
    reset = 1'b0;
    step();
    check_val("f_rst_valid", rd_req_valid, 0);
    check_val("f_rst_busy", busy, 0);
    check_val("f_rst_addr", rd_req_addr, 0);
    check_val("f_rst_inval", inval, 0);
    check_val("f_rst_done", done, 0);
    check_val("f_rst_stall", stall_cnt, 0);
    reset = 1'b1;
    exp_addr.delete();
    exp_inval.delete();
    cleared = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/glb_ld_dma_addr_gen.md
# glb_ld_dma_addr_gen

Load-DMA address generator for one global-buffer tile. It consumes the tile's load DMA header queue and walks each valid header's 4-level iteration space. For every word it issues a read address to the tile bank-read path, honouring the active/inactive gap pattern. On completion it returns a one-cycle invalidate pulse per header to the tile configuration register block.

## Interface
Parameters:
- QUEUE_DEPTH, 4, number of load DMA headers
- LOOP_LEVEL, 4, nested iteration levels per header
- GLB_ADDR_WIDTH, 19, byte address width
- MAX_NUM_WORDS_WIDTH, 16, width of range fields
- MAX_STRIDE_WIDTH, 16, width of stride fields (bytes, unsigned)

Ports:
- clk  in  1  clock
- reset  in  1  one clock; reset is synchronous and active-low
- cfg_ld_dma_mode  in  2  0 OFF, 1 NORMAL, 2 AUTO, 3 treated as OFF
- cfg_ld_dma_header  in  dma_ld_header_t [QUEUE_DEPTH]  header queue (valid, start_addr, num_active_words, num_inactive_words, iteration[LOOP_LEVEL].range/stride)
- ld_dma_start_pulse  in  1  begin processing at queue entry 0
- rd_req_valid  out  1  read request valid
- rd_req_ready  in  1  read path accepts request
- rd_req_addr  out  GLB_ADDR_WIDTH  read byte address
- cfg_load_dma_invalidate_pulse  out  1 [QUEUE_DEPTH]  one-cycle clear of header valid
- ld_dma_done_pulse  out  1  NORMAL-mode sequence finished
- ld_dma_busy  out  1  high in any state other than IDLE
- ld_dma_stall_cnt  out  32  backpressure cycle count (see Configuration)

## Operation
- States: IDLE, CHECK, ACTIVE, INACTIVE, DONE.
- IDLE -> CHECK on ld_dma_start_pulse with mode NORMAL/AUTO; q_ptr = 0. The start pulse is ignored in any other state.
- CHECK with header[q_ptr].valid=1:
  - load idx[*]=0, addr=start_addr, act_cnt=0;
  - go to ACTIVE.
- CHECK with header[q_ptr].valid=0:
  - NORMAL: go to DONE.
  - AUTO: stay in CHECK (poll).
- ACTIVE:
  - rd_req_valid=1, rd_req_addr = start_addr + Σ idx[i]*stride[i], truncated mod 2^GLB_ADDR_WIDTH.
  - Addresses are maintained incrementally with per-level base registers; no multipliers.
  - Each valid&ready handshake advances idx[0]. Level i wraps at range[i]-1 and carries into level i+1. A range of 0 is treated as 1.
- Gap pattern:
  - After num_active_words handshakes, if num_inactive_words≠0, go to INACTIVE.
  - INACTIVE counts num_inactive_words cycles, independent of ready, then returns to ACTIVE.
  - num_active_words=0 means no gaps.
- Header completion:
  - After the handshake where all levels wrap, assert cfg_load_dma_invalidate_pulse[q_ptr] for exactly one cycle.
  - q_ptr = (q_ptr+1) mod QUEUE_DEPTH, then go to CHECK.
  - NORMAL goes to DONE after entry QUEUE_DEPTH-1 completes. AUTO wraps to entry 0.
- DONE: ld_dma_done_pulse=1 for one cycle, then IDLE.
- Mode set to OFF in any non-IDLE state: next cycle is IDLE. The pending request is dropped with no invalidate and no done pulse.
- Header fields are sampled live. Software must not modify a header while its entry is in ACTIVE or INACTIVE.

## Timing
- Reset values: all outputs 0; state IDLE; q_ptr, idx, counters, addr all 0.
- Start pulse at cycle T: CHECK at T+1. First rd_req_valid at T+2 if entry 0 is valid.
- Back-to-back handshakes give 1 address per cycle with no bubble inside a header.
- Between headers there are 2 bubble cycles: the invalidate/CHECK cycle and the load cycle.
- rd_req_valid and rd_req_addr stay stable while valid&!ready (AXI-style; valid never drops without a handshake, except on abort or reset).
- Invalidate pulse: registered, in the cycle after the final handshake.
- Simultaneous events:
  - hwclr and a software write landing in the same cycle are resolved downstream.
  - ready arriving on the last active word before a gap still counts that word.
- Reset low mid-transfer: state and all outputs return to reset values on that clock edge.

## Configuration
- GLB_LD_DMA_STALL_CNT_EN defined: ld_dma_stall_cnt increments, saturating at 2^32-1, on every cycle with rd_req_valid&!rd_req_ready. It clears on ld_dma_start_pulse accepted in IDLE and on reset.
- Not defined: ld_dma_stall_cnt is tied to 0 and no counter flops are built.

## Test plan
- Header 0 only: valid, start_addr=0x100, range0=4, stride0=8, num_active_words=0, mode NORMAL, ready=1.
  - Addresses: 0x100, 0x108, 0x110, 0x118 on consecutive cycles.
  - invalidate[0] one cycle later; done pulse after CHECK sees entry 1 invalid.
- Two levels: range0=2 stride0=8, range1=3 stride1=0x40.
  - Addresses: 0x0, 0x8, 0x40, 0x48, 0x80, 0x88.
- Gaps: range0=6, active=2, inactive=3, ready=1.
  - Valid pattern: 110001100011; exactly 6 handshakes.
- Backpressure: ready low for 5 cycles mid-header.
  - Addr and valid held constant.
  - With the macro defined, stall_cnt=5 at end.
- AUTO mode: all 4 entries valid.
  - Invalidates fire in order 0,1,2,3.
  - Block then polls entry 0. Setting mode to OFF leads to IDLE next cycle with no done pulse.
- Reset low during the 3rd word: next cycle all outputs 0 and busy=0.
